// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared configuration for the register-file writeback scheduler:
// datapath width, register count, the reserved PC register index and the
// arbiter FSM state encoding.
package regfile_wb_scheduler_pkg;

  localparam int          ADDRESS_LEN  = 32;
  localparam int          NUM_REGS     = 15;
  localparam int          STARVE_LIMIT = 4;
  localparam logic [3:0]  REG_PC       = 4'd15;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_EXE = 1'b1
  } pri_e;

endpackage

// File: rtl/regfile_wb_scheduler_scoreboard.sv
// Pending-write scoreboard for ID-stage hazard detection.
// Ports:
//   clk, rst                 clock, async active-high reset
//   clr_en_i, clr_dest_i     writeback transfer releasing a register
//   issue_en_i, issue_dest_i ID reservation request
//   issue_ready_o            reservation allowed (destination not busy)
//   chk_src1_i, chk_src2_i,
//   chk_two_src_i            ID sources to test
//   hazard_o                 a used source has a pending write
//   busy_mask_o              bit i = Ri has a pending write
module regfile_wb_scheduler_scoreboard
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NUM_REGS = regfile_wb_scheduler_pkg::NUM_REGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_en_i,
  input  logic [3:0]          clr_dest_i,
  input  logic                issue_en_i,
  input  logic [3:0]          issue_dest_i,
  output logic                issue_ready_o,
  input  logic [3:0]          chk_src1_i,
  input  logic [3:0]          chk_src2_i,
  input  logic                chk_two_src_i,
  output logic                hazard_o,
  output logic [NUM_REGS-1:0] busy_mask_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [15:0]         busy_ext;
  logic [15:0]         set_oh, clr_oh;

  // Zero-extended view so any 4-bit index is in range; unimplemented
  // registers (including R15) always read as not busy.
  assign busy_ext = 16'(busy_q);

  assign issue_ready_o = ~busy_ext[issue_dest_i];

  assign hazard_o = (busy_ext[chk_src1_i] && (chk_src1_i != REG_PC)) ||
                    (chk_two_src_i && busy_ext[chk_src2_i] && (chk_src2_i != REG_PC));

  // One-hot masks are truncated to NUM_REGS, so R15 / out-of-range
  // destinations fall off the top and never touch the scoreboard.
  always_comb begin
    set_oh = '0;
    clr_oh = '0;
    if (issue_en_i && issue_ready_o) set_oh = 16'(1) << issue_dest_i;
    if (clr_en_i)                    clr_oh = 16'(1) << clr_dest_i;
    busy_d = (busy_q & ~clr_oh[NUM_REGS-1:0]) | set_oh[NUM_REGS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_mask_o = busy_q;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates the single register-file write port between the MEM (load)
// and EXE (ALU) writeback paths, with starvation protection for EXE, and
// hosts the pending-write scoreboard.
// Ports:
//   clk, rst                         clock, async active-high reset
//   mem_valid/dest/data, mem_ready   MEM writeback request / accept
//   exe_valid/dest/data, exe_ready   EXE writeback request / accept
//   issue_en, issue_dest, issue_ready  ID destination reservation
//   chk_src1, chk_src2, chk_two_src, hazard  ID hazard check
//   busy_mask                        scoreboard
//   wb_en, dest_wb, result_wb        registered register-file write port
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int ADDRESS_LEN  = regfile_wb_scheduler_pkg::ADDRESS_LEN,
  parameter int NUM_REGS     = regfile_wb_scheduler_pkg::NUM_REGS,
  parameter int STARVE_LIMIT = regfile_wb_scheduler_pkg::STARVE_LIMIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_valid,
  input  logic [3:0]             mem_dest,
  input  logic [ADDRESS_LEN-1:0] mem_data,
  output logic                   mem_ready,
  input  logic                   exe_valid,
  input  logic [3:0]             exe_dest,
  input  logic [ADDRESS_LEN-1:0] exe_data,
  output logic                   exe_ready,
  input  logic                   issue_en,
  input  logic [3:0]             issue_dest,
  output logic                   issue_ready,
  input  logic [3:0]             chk_src1,
  input  logic [3:0]             chk_src2,
  input  logic                   chk_two_src,
  output logic                   hazard,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic                   wb_en,
  output logic [3:0]             dest_wb,
  output logic [ADDRESS_LEN-1:0] result_wb
);

  localparam int         CW      = $clog2(STARVE_LIMIT);
  localparam logic [CW-1:0] CNT_TOP = CW'(STARVE_LIMIT - 1);
  localparam logic [3:0] NREG4   = 4'(NUM_REGS);

  pri_e                   state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   wb_en_q, wb_en_d;
  logic [3:0]             dest_wb_q, dest_wb_d;
  logic [ADDRESS_LEN-1:0] result_wb_q, result_wb_d;

  logic                   both, xfer, dest_ok;
  logic [3:0]             sel_dest;
  logic [ADDRESS_LEN-1:0] sel_data;

  assign both = mem_valid && exe_valid;

  // State register (priority holder + starvation counter).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PRI_MEM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. The flip happens on the denial that finds the counter
  // already at LIMIT-1, so EXE loses exactly STARVE_LIMIT times in a row.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (exe_ready) begin
      cnt_d   = '0;
      state_d = PRI_MEM;
    end else if (both) begin
      if (cnt_q == CNT_TOP) state_d = PRI_EXE;
      else                  cnt_d   = cnt_q + CW'(1);
    end
  end

  // Outputs: ready only to the winner; a lone requester always wins.
  always_comb begin
    mem_ready = 1'b0;
    exe_ready = 1'b0;
    if (both) begin
      if (state_q == PRI_EXE) exe_ready = 1'b1;
      else                    mem_ready = 1'b1;
    end else begin
      mem_ready = mem_valid;
      exe_ready = exe_valid;
    end
  end

  assign xfer     = mem_ready || exe_ready;
  assign sel_dest = mem_ready ? mem_dest : exe_dest;
  assign sel_data = mem_ready ? mem_data : exe_data;
  // Writes to PC or unimplemented registers are accepted but swallowed.
  assign dest_ok  = (sel_dest < NREG4) && (sel_dest != REG_PC);

  always_comb begin
    wb_en_d     = 1'b0;
    dest_wb_d   = dest_wb_q;
    result_wb_d = result_wb_q;
    if (xfer && dest_ok) begin
      wb_en_d     = 1'b1;
      dest_wb_d   = sel_dest;
      result_wb_d = sel_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q     <= 1'b0;
      dest_wb_q   <= '0;
      result_wb_q <= '0;
    end else begin
      wb_en_q     <= wb_en_d;
      dest_wb_q   <= dest_wb_d;
      result_wb_q <= result_wb_d;
    end
  end

  assign wb_en     = wb_en_q;
  assign dest_wb   = dest_wb_q;
  assign result_wb = result_wb_q;

  // Busy bit clears at the same edge the write is registered; the file
  // commits on the following negedge, before ID can read it.
  regfile_wb_scheduler_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .clr_en_i     (xfer),
    .clr_dest_i   (sel_dest),
    .issue_en_i   (issue_en),
    .issue_dest_i (issue_dest),
    .issue_ready_o(issue_ready),
    .chk_src1_i   (chk_src1),
    .chk_src2_i   (chk_src2),
    .chk_two_src_i(chk_two_src),
    .hazard_o     (hazard),
    .busy_mask_o  (busy_mask)
  );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, exe_valid, issue_en, chk_two_src;
  logic [3:0]  mem_dest, exe_dest, issue_dest, chk_src1, chk_src2;
  logic [31:0] mem_data, exe_data;
  logic        mem_ready, exe_ready, issue_ready, hazard, wb_en;
  logic [14:0] busy_mask;
  logic [3:0]  dest_wb;
  logic [31:0] result_wb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .exe_valid(exe_valid), .exe_dest(exe_dest), .exe_data(exe_data), .exe_ready(exe_ready),
    .issue_en(issue_en), .issue_dest(issue_dest), .issue_ready(issue_ready),
    .chk_src1(chk_src1), .chk_src2(chk_src2), .chk_two_src(chk_two_src), .hazard(hazard),
    .busy_mask(busy_mask), .wb_en(wb_en), .dest_wb(dest_wb), .result_wb(result_wb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mem_valid = 0; exe_valid = 0; issue_en = 0; chk_two_src = 0;
    mem_dest = 0; exe_dest = 0; issue_dest = 0; chk_src1 = 0; chk_src2 = 0;
    mem_data = 0; exe_data = 0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_dest", 32'(dest_wb), 32'd0);
    chk("rst_result", result_wb, 32'd0);
    chk("rst_busy", 32'(busy_mask), 32'd0);

    // Lone MEM request to R3 (R3 reserved first so the clear is visible).
    tick();
    issue_en = 1; issue_dest = 3;
    #1 chk("t2_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_en = 0;
    chk("t2_busy3_set", 32'(busy_mask), 32'h0008);
    mem_valid = 1; mem_dest = 3; mem_data = 32'hDEAD;
    #1 chk("t2_mem_ready", 32'(mem_ready), 32'd1);
    chk("t2_exe_ready", 32'(exe_ready), 32'd0);
    tick();
    mem_valid = 0;
    chk("t2_wb_en", 32'(wb_en), 32'd1);
    chk("t2_dest", 32'(dest_wb), 32'd3);
    chk("t2_result", result_wb, 32'hDEAD);
    chk("t2_busy_clr", 32'(busy_mask), 32'd0);
    tick();
    chk("t2_wb_en_drop", 32'(wb_en), 32'd0);
    chk("t2_dest_hold", 32'(dest_wb), 32'd3);
    chk("t2_result_hold", result_wb, 32'hDEAD);

    // Scoreboard on R5.
    issue_en = 1; issue_dest = 5;
    tick();
    chk("t4_busy5", 32'(busy_mask), 32'h0020);
    #1 chk("t4_reissue_blocked", 32'(issue_ready), 32'd0);
    issue_en = 0;
    chk_src1 = 5; chk_src2 = 4; chk_two_src = 0;
    #1 chk("t4_hazard_src1", 32'(hazard), 32'd1);
    chk_src1 = 4; chk_src2 = 5;
    #1 chk("t4_src2_unused", 32'(hazard), 32'd0);
    chk_two_src = 1;
    #1 chk("t4_hazard_src2", 32'(hazard), 32'd1);
    chk_two_src = 0;
    exe_valid = 1; exe_dest = 5; exe_data = 32'h0000_0555;
    #1 chk("t4_exe_ready", 32'(exe_ready), 32'd1);
    tick();
    exe_valid = 0;
    chk("t4_wb_en", 32'(wb_en), 32'd1);
    chk("t4_dest", 32'(dest_wb), 32'd5);
    chk("t4_result", result_wb, 32'h0000_0555);
    chk("t4_busy5_clr", 32'(busy_mask), 32'd0);

    // R15 is accepted but never written or reserved.
    exe_valid = 1; exe_dest = 15; exe_data = 32'h1234;
    #1 chk("t5_exe_ready", 32'(exe_ready), 32'd1);
    tick();
    exe_valid = 0;
    chk("t5_wb_en", 32'(wb_en), 32'd0);
    chk("t5_dest_hold", 32'(dest_wb), 32'd5);
    issue_en = 1; issue_dest = 15;
    #1 chk("t5_issue_ready", 32'(issue_ready), 32'd1);
    tick();
    issue_en = 0;
    chk("t5_busy", 32'(busy_mask), 32'd0);

    // Issue R2 while a MEM write releases R7.
    issue_en = 1; issue_dest = 7;
    tick();
    chk("t6_busy7", 32'(busy_mask), 32'h0080);
    issue_dest = 2;
    mem_valid = 1; mem_dest = 7; mem_data = 32'h77;
    #1 chk("t6_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    issue_en = 0; mem_valid = 0;
    chk("t6_busy", 32'(busy_mask), 32'h0004);
    chk("t6_dest", 32'(dest_wb), 32'd7);

    // Starvation: both valid for 6 cycles -> M,M,M,M,E,M.
    mem_valid = 1; mem_dest = 1; exe_valid = 1; exe_dest = 9;
    for (int i = 0; i < 6; i++) begin
      mem_data = 32'h100 + 32'(i);
      exe_data = 32'h900 + 32'(i);
      #1;
      chk($sformatf("t3_mem_ready_%0d", i), 32'(mem_ready), (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("t3_exe_ready_%0d", i), 32'(exe_ready), (i == 4) ? 32'd1 : 32'd0);
      tick();
      chk($sformatf("t3_dest_%0d", i), 32'(dest_wb), (i == 4) ? 32'd9 : 32'd1);
    end
    mem_valid = 0; exe_valid = 0;

    // Asynchronous reset mid-cycle with live state.
    issue_en = 1; issue_dest = 4;
    mem_valid = 1; mem_dest = 6; mem_data = 32'hCAFE;
    tick();
    issue_en = 0; mem_valid = 0;
    chk("t1_pre_wb_en", 32'(wb_en), 32'd1);
    chk("t1_pre_busy", 32'(busy_mask), 32'h0014);
    #3 rst = 1'b1;
    #1;
    chk("t1_wb_en", 32'(wb_en), 32'd0);
    chk("t1_dest", 32'(dest_wb), 32'd0);
    chk("t1_result", result_wb, 32'd0);
    chk("t1_busy", 32'(busy_mask), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t1_post_wb_en", 32'(wb_en), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
